demux1to4_buffered: RTL and testbench

//  Inverse of the 4-to-1 selector path: routes one W-bit input stream to one of

---
 rtl/demux1to4_buffered.sv | 99 +++++++++
 tb/tb_demux1to4_buffered.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_buffered.sv
// One-to-four demultiplexer with a one-word valid/ready buffer per output channel.
// Define DEMUX_ROUNDROBIN_EN to take the destination from an internal round-robin pointer instead of s.
module demux1to4_buffered #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [1:0]   s,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic [3:0]   q_valid,
  input  logic [3:0]   q_ready,
  output logic [7:0]   drop_cnt
);

  logic [3:0][W-1:0] data_q, data_d;
  logic [3:0]        valid_q, valid_d;
  logic [7:0]        drop_q, drop_d;
  logic [1:0]        dst_s;
  logic              accept_s;

`ifdef DEMUX_ROUNDROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_s;

  assign unused_s = ^s;
  assign dst_s    = ptr_q;

  // Pointer advances only on accept, so a stalled channel is never skipped.
  always_comb begin
    if (accept_s) begin
      ptr_d = ptr_q + 2'd1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign dst_s = s;
`endif

  assign d_ready  = ~valid_q[dst_s] | q_ready[dst_s];
  assign accept_s = d_valid & d_ready;

  // A write to a channel wins over its drain, keeping valid high for back-to-back words.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      if (accept_s && (dst_s == 2'(i))) begin
        data_d[i]  = d;
        valid_d[i] = 1'b1;
      end else begin
        data_d[i]  = data_q[i];
        valid_d[i] = valid_q[i] & ~q_ready[i];
      end
    end
  end

  always_comb begin
    if (d_valid && !d_ready && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
      drop_q  <= 8'd0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign q0       = data_q[0];
  assign q1       = data_q[1];
  assign q2       = data_q[2];
  assign q3       = data_q[3];
  assign q_valid  = valid_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux1to4_buffered.sv
// Directed + random bench for demux1to4_buffered with a per-channel scoreboard of delivered words.
module tb_demux1to4_buffered;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d;
  logic         d_valid;
  logic         d_ready;
  logic [1:0]   s;
  logic [W-1:0] q0, q1, q2, q3;
  logic [3:0]   q_valid;
  logic [3:0]   q_ready;
  logic [7:0]   drop_cnt;
  logic [W-1:0] q_arr [4];

  demux1to4_buffered #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_ready(d_ready), .s(s),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .q_valid(q_valid), .q_ready(q_ready), .drop_cnt(drop_cnt)
  );

  assign q_arr[0] = q0;
  assign q_arr[1] = q1;
  assign q_arr[2] = q2;
  assign q_arr[3] = q3;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [3:0] exp_v;
  logic [7:0] exp_drop;
  logic [1:0] exp_ptr;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take(input logic [1:0] ch, output logic [W-1:0] data);
    logic found;
    found = 1'b0;
    data  = '0;
    for (int k = 0; k < sb.size(); k++) begin
      if (!found && sb[k].ch == ch) begin
        data  = sb[k].data;
        sb.delete(k);
        found = 1'b1;
        break;
      end
    end
    chk("sb_hit", 32'(found), 32'd1);
  endtask

  task automatic model_reset();
    sb.delete();
    exp_v    = 4'b0000;
    exp_drop = 8'd0;
    exp_ptr  = 2'd0;
  endtask

  // One clock: check handshake and deliveries before the edge, state after it.
  task automatic cycle();
    logic [1:0]   dst;
    logic         rdy;
    logic [W-1:0] got;
    sb_t          item;
    #1;
`ifdef DEMUX_ROUNDROBIN_EN
    dst = exp_ptr;
`else
    dst = s;
`endif
    rdy = !exp_v[dst] || q_ready[dst];
    chk("d_ready", 32'(d_ready), 32'(rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_v[i] && q_ready[i]) begin
        take(2'(i), got);
        chk($sformatf("q%0d_data", i), 32'(q_arr[i]), 32'(got));
        exp_v[i] = 1'b0;
      end
    end
    if (d_valid && rdy) begin
      item.ch   = dst;
      item.data = d;
      sb.push_back(item);
      exp_v[dst] = 1'b1;
      exp_ptr    = exp_ptr + 2'd1;
    end else if (d_valid && exp_drop != 8'hFF) begin
      exp_drop = exp_drop + 8'd1;
    end
    @(posedge clk);
    #1;
    chk("q_valid", 32'(q_valid), 32'(exp_v));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic drive(input logic v, input logic [W-1:0] dd, input logic [1:0] ss, input logic [3:0] rr);
    d_valid = v;
    d       = dd;
    s       = ss;
    q_ready = rr;
    cycle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst_n   = 1'b0;
    d_valid = 1'b1;
    d       = 2'd3;
    s       = 2'd2;
    q_ready = 4'b0000;
    model_reset();

    // Reset held with a pending word: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q0", 32'(q0), 32'd0);
    chk("rst_q1", 32'(q1), 32'd0);
    chk("rst_q2", 32'(q2), 32'd0);
    chk("rst_q3", 32'(q3), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    d_valid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;

`ifndef DEMUX_ROUNDROBIN_EN
    // Routing with all consumers ready.
    drive(1'b1, 2'd1, 2'd0, 4'b1111);
    drive(1'b1, 2'd2, 2'd1, 4'b1111);
    drive(1'b1, 2'd3, 2'd2, 4'b1111);
    drive(1'b1, 2'd0, 2'd3, 4'b1111);
    drive(1'b0, 2'd0, 2'd0, 4'b1111);
    chk("route_q0", 32'(q0), 32'd1);
    chk("route_q1", 32'(q1), 32'd2);
    chk("route_q2", 32'(q2), 32'd3);
    chk("route_q3", 32'(q3), 32'd0);

    // Backpressure on channel 1.
    drive(1'b1, 2'd2, 2'd1, 4'b0000);
    chk("bp_q_valid", 32'(q_valid), 32'b0010);
    repeat (3) drive(1'b1, 2'd3, 2'd1, 4'b0000);
    chk("bp_drop3", 32'(drop_cnt), 32'd3);
    chk("bp_q1_hold", 32'(q1), 32'd2);
    drive(1'b1, 2'd3, 2'd1, 4'b0010);
    chk("bp_q1_new", 32'(q1), 32'd3);

    // Same-cycle drain and write on channel 2.
    drive(1'b1, 2'd2, 2'd2, 4'b0000);
    drive(1'b1, 2'd1, 2'd2, 4'b0100);
    chk("dw_q2", 32'(q2), 32'd1);
    chk("dw_q_valid", 32'(q_valid), 32'b0110);
    chk("dw_q1_kept", 32'(q1), 32'd3);

    // Ready on an empty channel is harmless; then a long stall saturates drop_cnt.
    drive(1'b0, 2'd0, 2'd0, 4'b1001);
    repeat (300) drive(1'b1, 2'd0, 2'd1, 4'b0000);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    drive(1'b0, 2'd0, 2'd0, 4'b1111);
`else
    // Round-robin: s ignored, words land on q0,q1,q2,q3,q0.
    drive(1'b1, 2'd0, 2'd0, 4'b1111);
    drive(1'b1, 2'd1, 2'd0, 4'b1111);
    drive(1'b1, 2'd2, 2'd0, 4'b1111);
    drive(1'b1, 2'd3, 2'd0, 4'b1111);
    drive(1'b1, 2'd1, 2'd0, 4'b1111);
    drive(1'b0, 2'd0, 2'd0, 4'b1111);
    chk("rr_q0", 32'(q0), 32'd1);
    chk("rr_q1", 32'(q1), 32'd1);
    chk("rr_q2", 32'(q2), 32'd2);
    chk("rr_q3", 32'(q3), 32'd3);
    // Channel 2 never drains, so the pointer parks on it.
    for (int i = 0; i < 8; i++) drive(1'b1, W'(i), 2'd0, 4'b1011);
    chk("rr_q2_full", 32'(q_valid[2]), 32'd1);
    drive(1'b1, 2'd3, 2'd0, 4'b1111);
    drive(1'b0, 2'd0, 2'd0, 4'b1111);
`endif

    // Random traffic checked against the model and scoreboard.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 2'($urandom), 4'($urandom));
    end

    // Reset asserted while a word is buffered clears state immediately.
    drive(1'b1, 2'd1, 2'd0, 4'b0000);
    d_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q_valid", 32'(q_valid), 32'd0);
    chk("async_rst_q0", 32'(q0), 32'd0);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_q_valid", 32'(q_valid), 32'd0);
    d_valid = 1'b0;
    rst_n   = 1'b1;
    model_reset();
    drive(1'b1, 2'd2, 2'd3, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
